// File: rtl/signed_seq_divider.sv
// rtl/signed_seq_divider.sv - sequential signed restoring divider, 2n/n -> n quotient and remainder
//
// Divides a 2n-bit signed dividend by an n-bit signed divisor, one quotient
// bit per cycle, behind a start/busy/done handshake. Results truncate toward
// zero and match SystemVerilog signed / and %.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request, sampled only while idle
//   dividend     2n-bit signed dividend, latched on an accepted start
//   divisor      n-bit signed divisor, latched on an accepted start
//   busy         high while an operation is in flight
//   done         one-cycle pulse, results valid from this cycle on
//   quotient     n-bit signed quotient (low n bits of the true quotient)
//   remainder    n-bit signed remainder, sign of the dividend or zero
//   overflow     true quotient does not fit n signed bits, or divisor is zero
//   div_by_zero  divisor was zero
module signed_seq_divider #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*n-1:0] dividend,
    input  logic [n-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [n-1:0]   quotient,
    output logic [n-1:0]   remainder,
    output logic           overflow,
    output logic           div_by_zero
);

    localparam int cw = $clog2(2 * n);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        FIN
    } state_t;

    state_t state;
    state_t next_state;

    logic [2*n-1:0] dvd_reg;
    logic [n-1:0]   dvs_reg;
    // Holds the dividend magnitude, then shifts quotient bits in from the LSB.
    logic [2*n-1:0] dvd_mag;
    logic [n-1:0]   dvs_mag;
    logic [n:0]     part_rem;
    logic [cw-1:0]  count;
    logic           neg_q;
    logic           neg_r;

    logic [n+1:0]   shifted;
    logic [n+1:0]   diff;
    logic           take;
    logic [2*n:0]   q_ext;
    logic [2*n:0]   q_signed;
    logic [n-1:0]   r_signed;
    logic           q_out_of_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = LOAD;
            LOAD: next_state = DIV;
            DIV:  if (count == cw'(2 * n - 1)) next_state = FIN;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One restoring step: the extra top bit of the trial difference is its sign,
    // so a clear sign bit means the subtraction is kept.
    always_comb begin
        shifted = {part_rem, dvd_mag[2*n-1]};
        diff    = shifted - {2'b00, dvs_mag};
        take    = ~diff[n+1];
    end

    // The magnitude quotient can be 2^(2n-1) (e.g. most-negative / -1), so the
    // sign is applied in 2n+1 bits to keep the range test exact.
    always_comb begin
        q_ext          = {1'b0, dvd_mag};
        q_signed       = neg_q ? -q_ext : q_ext;
        r_signed       = neg_r ? -part_rem[n-1:0] : part_rem[n-1:0];
        q_out_of_range = !((&q_signed[2*n:n-1]) || (~|q_signed[2*n:n-1]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            dvd_mag     <= '0;
            dvs_mag     <= '0;
            part_rem    <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_reg <= dividend;
                        dvs_reg <= divisor;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    neg_r    <= dvd_reg[2*n-1];
                    neg_q    <= dvd_reg[2*n-1] ^ dvs_reg[n-1];
                    dvd_mag  <= dvd_reg[2*n-1] ? -dvd_reg : dvd_reg;
                    dvs_mag  <= dvs_reg[n-1] ? -dvs_reg : dvs_reg;
                    part_rem <= '0;
                    count    <= '0;
                end
                DIV: begin
                    part_rem <= take ? diff[n:0] : shifted[n:0];
                    dvd_mag  <= {dvd_mag[2*n-2:0], take};
                    count    <= count + cw'(1);
                end
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (dvs_reg == '0) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        overflow    <= 1'b1;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_signed[n-1:0];
                        remainder   <= r_signed;
                        overflow    <= q_out_of_range;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb/tb_signed_seq_divider.sv - directed self-checking bench for signed_seq_divider
module tb_signed_seq_divider;

    localparam int n = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [2*n-1:0] dividend = '0;
    logic [n-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [n-1:0]   quotient;
    logic [n-1:0]   remainder;
    logic           overflow;
    logic           div_by_zero;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    signed_seq_divider #(.n(n)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .overflow(overflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issues one operation and returns at the negedge where done is seen.
    // lat counts edges from the accepting edge to the edge that raised done.
    task automatic run_op(input logic [2*n-1:0] dvd, input logic [n-1:0] dvs,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        int lat;
        bit bok;
        int seen_done;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, quotient, remainder, overflow, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0",
                     {busy, done, quotient, remainder, overflow, div_by_zero});
        end
        reset = 1'b0;
        run_op(16'd100, 8'd7, lat, bok);
        n_checks++;
        if (quotient !== 8'd14 || remainder !== 8'd2) begin
            n_fail++;
            $display("FAIL pre_reset_op: got q=%0d r=%0d expected q=14 r=2", quotient, remainder);
        end
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, overflow, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL mid_op_reset: got %h expected 0",
                     {busy, done, quotient, remainder, overflow, div_by_zero});
        end
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL no_done_after_abort: got %0d active cycles expected 0", seen_done);
        end
    endtask

    task automatic test_signs;
        int dv[4] = '{100, -100, 100, -100};
        int ds[4] = '{7, 7, -7, -7};
        int eq[4] = '{14, -14, -14, 14};
        int er[4] = '{2, -2, 2, -2};
        int lat;
        bit bok;
        logic [n-1:0] xq, xr;
        for (int i = 0; i < 4; i++) begin
            run_op(16'(dv[i]), 8'(ds[i]), lat, bok);
            xq = 8'(eq[i]);
            xr = 8'(er[i]);
            n_checks++;
            if (lat != 18) begin
                n_fail++;
                $display("FAIL sign_latency[%0d]: got %0d expected 18", i, lat);
            end
            n_checks++;
            if (!bok) begin
                n_fail++;
                $display("FAIL sign_busy[%0d]: got busy profile wrong expected high until done", i);
            end
            n_checks++;
            if (quotient !== xq || remainder !== xr || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL sign_result[%0d]: got q=%h r=%h ov=%b dz=%b expected q=%h r=%h ov=0 dz=0",
                         i, quotient, remainder, overflow, div_by_zero, xq, xr);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse[%0d]: got %b expected 0", i, done);
            end
        end
    endtask

    task automatic test_extremes_overflow;
        int dv[5] = '{-16256, -16256, 127, -32768, 1000};
        int ds[5] = '{127, -128, -128, -1, 7};
        logic [n-1:0] eq[5] = '{8'h80, 8'h7F, 8'h00, 8'h00, 8'h8E};
        logic [n-1:0] er[5] = '{8'h00, 8'h00, 8'h7F, 8'h00, 8'h06};
        logic eo[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        bit bok;
        for (int i = 0; i < 5; i++) begin
            run_op(16'(dv[i]), 8'(ds[i]), lat, bok);
            n_checks++;
            if (lat != 18 || quotient !== eq[i] || remainder !== er[i] ||
                overflow !== eo[i] || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL extreme[%0d]: got lat=%0d q=%h r=%h ov=%b dz=%b expected lat=18 q=%h r=%h ov=%b dz=0",
                         i, lat, quotient, remainder, overflow, div_by_zero, eq[i], er[i], eo[i]);
            end
        end
    endtask

    task automatic test_div_by_zero;
        int lat;
        bit bok;
        run_op(16'd1234, 8'd0, lat, bok);
        n_checks++;
        if (lat != 18 || quotient !== 8'd0 || remainder !== 8'd0 ||
            overflow !== 1'b1 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL div_zero: got lat=%0d q=%h r=%h ov=%b dz=%b expected lat=18 q=00 r=00 ov=1 dz=1",
                     lat, quotient, remainder, overflow, div_by_zero);
        end
        run_op(16'd20, 8'd3, lat, bok);
        n_checks++;
        if (quotient !== 8'd6 || remainder !== 8'd2 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL after_zero: got q=%h r=%h ov=%b dz=%b expected q=06 r=02 ov=0 dz=0",
                     quotient, remainder, overflow, div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        int dv[3] = '{100, -100, 1000};
        int ds[3] = '{7, -7, 7};
        logic [n-1:0] eq[3] = '{8'd14, 8'd14, 8'h8E};
        logic [n-1:0] er[3] = '{8'd2, 8'hFE, 8'd6};
        int k = 0;
        int last = 0;
        int guard = 0;
        @(negedge clk);
        dividend = 16'(dv[0]);
        divisor  = 8'(ds[0]);
        start    = 1'b1;
        while (k < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (done === 1'b1) begin
                n_checks++;
                if (quotient !== eq[k] || remainder !== er[k]) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got q=%h r=%h expected q=%h r=%h",
                             k, quotient, remainder, eq[k], er[k]);
                end
                if (k > 0) begin
                    n_checks++;
                    if (cyc - last != 2 * n + 3) begin
                        n_fail++;
                        $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, cyc - last, 2 * n + 3);
                    end
                end
                last = cyc;
                k++;
                if (k < 3) begin
                    dividend = 16'(dv[k]);
                    divisor  = 8'(ds[k]);
                end else begin
                    start = 1'b0;
                end
            end else begin
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
        end
        start = 1'b0;
        n_checks++;
        if (k != 3) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d completions expected 3", k);
        end
    endtask

    task automatic test_round_trip;
        int bs[10] = '{1, -1, 2, -3, 7, -64, 127, -128, 13, -100};
        int lat;
        bit bok;
        int bad = 0;
        logic [n-1:0] xa;
        for (int a = -128; a <= 127; a += 5) begin
            for (int j = 0; j < 10; j++) begin
                run_op(16'(a * bs[j]), 8'(bs[j]), lat, bok);
                xa = 8'(a);
                n_checks++;
                if (lat != 18 || quotient !== xa || remainder !== 8'd0 || overflow !== 1'b0) begin
                    n_fail++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL round_trip a=%0d b=%0d: got lat=%0d q=%h r=%h ov=%b expected lat=18 q=%h r=00 ov=0",
                                 a, bs[j], lat, quotient, remainder, overflow, xa);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_signs();
        test_extremes_overflow();
        test_div_by_zero();
        test_back_to_back();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
